// File: rtl/uart_mem_loader_pkg.sv
// rtl/uart_mem_loader_pkg.sv - shared types and constants for the UART memory loader
package uart_mem_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BYTES      = DEF_DATA_W / 8;

  function automatic int unsigned num_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Start bit is re-checked half a bit after the falling edge.
  function automatic int unsigned half_bit_cnt(input int unsigned clks);
    return clks / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// rtl/uart_mem_loader_if.sv - memory write port and status bundle of the loader
interface uart_mem_loader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic [15:0]       word_cnt;
  logic              frame_err;
  logic              timeout_err;

  modport master (output wr, addr, data, busy, word_cnt, frame_err, timeout_err);
  modport slave  (input  wr, addr, data, busy, word_cnt, frame_err, timeout_err);
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 receiver: synchroniser, baud counter and RX FSM
module uart_rx_byte
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err_pulse,
  output logic       o_rx_idle
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(half_bit_cnt(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [1:0]       r_sync;
  logic             w_rx_s;

  assign w_rx_s    = r_sync[1];
  assign o_byte    = r_shift;
  assign o_rx_idle = (r_state == RX_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (!i_enable) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt + 1'b1;
    w_bit_nxt         = r_bit;
    w_shift_nxt       = r_shift;
    o_byte_valid      = 1'b0;
    o_frame_err_pulse = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (w_rx_s) o_byte_valid      = 1'b1;
          else        o_frame_err_pulse = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - packs received UART bytes little-endian into memory words
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned ADDR_STEP    = 1,
  parameter int unsigned TIMEOUT_CLKS = 16 * CLKS_PER_BIT * 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_uart_in,
  uart_mem_loader_if.master mem
);
  localparam int unsigned BYTES_L = num_bytes(DATA_W);
  localparam int IDX_W = (BYTES_L > 1) ? $clog2(BYTES_L) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]        w_byte;
  logic              w_byte_valid;
  logic              w_frame_err_pulse;
  logic              w_rx_idle;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [TO_W-1:0]   r_idle_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_word_cnt;
  logic              r_frame_err;
  logic              r_timeout_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_rx             (i_uart_in),
    .o_byte           (w_byte),
    .o_byte_valid     (w_byte_valid),
    .o_frame_err_pulse(w_frame_err_pulse),
    .o_rx_idle        (w_rx_idle)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || !i_enable) begin
      r_byte_idx    <= '0;
      r_idle_cnt    <= '0;
      r_wr          <= 1'b0;
      r_addr        <= BASE_ADDR;
      r_data        <= '0;
      r_word_cnt    <= '0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (r_wr) r_addr <= r_addr + ADDR_W'(ADDR_STEP);
      if (w_frame_err_pulse) r_frame_err <= 1'b1;
      if (w_byte_valid) begin
        r_data[8*r_byte_idx +: 8] <= w_byte;
        if (r_byte_idx == IDX_W'(BYTES_L - 1)) begin
          r_byte_idx <= '0;
          r_wr       <= 1'b1;
          if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
        end else begin
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
      // Byte delivery happens outside IDLE, so it never races the timeout below.
      if (!w_rx_idle || r_byte_idx == '0) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
        r_idle_cnt    <= '0;
        r_byte_idx    <= '0;
        r_timeout_err <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign mem.wr          = r_wr;
  assign mem.addr        = r_addr;
  assign mem.data        = r_data;
  assign mem.busy        = !w_rx_idle || (r_byte_idx != '0);
  assign mem.word_cnt    = r_word_cnt;
  assign mem.frame_err   = r_frame_err;
  assign mem.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed self-checking bench for uart_mem_loader
module tb_uart_mem_loader;
  localparam int CPB     = 16;
  localparam int TIMEOUT = 16 * CPB * 10;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic uart_in;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  uart_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) mif0 ();
  uart_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) mif1 ();

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .DATA_W(32), .ADDR_W(32),
                    .BASE_ADDR(32'h0), .ADDR_STEP(1), .TIMEOUT_CLKS(TIMEOUT)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_uart_in(uart_in), .mem(mif0));

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .DATA_W(32), .ADDR_W(32),
                    .BASE_ADDR(32'h100), .ADDR_STEP(4), .TIMEOUT_CLKS(TIMEOUT)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_uart_in(uart_in), .mem(mif1));

  always @(negedge clk) begin
    if (mif0.wr) q0.push_back({mif0.addr, mif0.data});
    if (mif1.wr) q1.push_back({mif1.addr, mif1.data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pop0();
    return (q0.size() > 0) ? q0.pop_front() : 64'hDEAD_0000_DEAD_0000;
  endfunction

  function automatic logic [63:0] pop1();
    return (q1.size() > 0) ? q1.pop_front() : 64'hDEAD_0000_DEAD_0000;
  endfunction

  task automatic send_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      uart_in = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({1'b1, b, 1'b0}, 10);
  endtask

  task automatic soft_clear();
    uart_in = 1'b1;
    enable  = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; uart_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr",    mif0.wr, 0);
    check("rst_addr0", mif0.addr, 32'h0);
    check("rst_addr1", mif1.addr, 32'h100);
    check("rst_data",  mif0.data, 0);
    check("rst_busy",  mif0.busy, 0);
    check("rst_cnt",   mif0.word_cnt, 0);
    check("rst_flags", {mif0.frame_err, mif0.timeout_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Single word
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    repeat (20) @(negedge clk);
    check("t1_nwr",  q0.size(), 1);
    check("t1_word", pop0(), {32'h0, 32'h1234_5678});
    check("t1_cnt",  mif0.word_cnt, 1);
    check("t1_busy", mif0.busy, 0);
    check("t1_addr_adv", mif0.addr, 32'h1);

    // Two back-to-back words on the byte-addressed instance
    soft_clear();
    check("clr_addr1", mif1.addr, 32'h100);
    check("clr_cnt",   mif1.word_cnt, 0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    repeat (20) @(negedge clk);
    check("t2_nwr", q1.size(), 2);
    check("t2_w0",  pop1(), {32'h100, 32'h0403_0201});
    check("t2_w1",  pop1(), {32'h104, 32'h0807_0605});
    check("t2_cnt", mif1.word_cnt, 2);
    check("t2_d0_w1", q0.size() > 1 ? q0[1] : 64'h0, {32'h1, 32'h0807_0605});

    // Start-bit glitch shorter than half a bit
    soft_clear();
    uart_in = 1'b0;
    repeat (5) @(negedge clk);
    uart_in = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_nwr",   q0.size(), 0);
    check("t3_busy",  mif0.busy, 0);
    check("t3_flags", {mif0.frame_err, mif0.timeout_err}, 0);
    check("t3_cnt",   mif0.word_cnt, 0);

    // Framing error: byte dropped, following word intact
    send_bits({1'b0, 8'hAA, 1'b0}, 10);
    uart_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t4_ferr", mif0.frame_err, 1);
    check("t4_busy", mif0.busy, 0);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    repeat (20) @(negedge clk);
    check("t4_nwr",  q0.size(), 1);
    check("t4_word", pop0(), {32'h0, 32'hDEAD_BEEF});
    check("t4_cnt",  mif0.word_cnt, 1);
    check("t4_ferr_sticky", mif0.frame_err, 1);

    // Partial-word timeout
    soft_clear();
    send_byte(8'hA1); send_byte(8'hA2);
    check("t5_busy_partial", mif0.busy, 1);
    repeat (TIMEOUT + 60) @(negedge clk);
    check("t5_terr", mif0.timeout_err, 1);
    check("t5_busy", mif0.busy, 0);
    check("t5_nwr0", q0.size(), 0);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    repeat (20) @(negedge clk);
    check("t5_word0", pop0(), {32'h0, 32'h1122_3344});
    check("t5_word1", pop1(), {32'h100, 32'h1122_3344});

    // Enable dropped mid-DATA of byte 3
    soft_clear();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    send_bits({1'b1, 8'h07, 1'b0}, 4);
    enable = 1'b0;
    @(negedge clk);
    check("t6_wr",   mif0.wr, 0);
    check("t6_busy", mif0.busy, 0);
    check("t6_addr", mif0.addr, 32'h0);
    check("t6_data", mif0.data, 0);
    check("t6_cnt",  mif0.word_cnt, 0);
    uart_in = 1'b1;
    repeat (CPB) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    q0.delete(); q1.delete();
    send_byte(8'hC4); send_byte(8'hC3); send_byte(8'hC2); send_byte(8'hC1);
    repeat (20) @(negedge clk);
    check("t6_nwr",  q0.size(), 1);
    check("t6_word", pop0(), {32'h0, 32'hC1C2_C3C4});
    check("t6_cnt",  mif0.word_cnt, 1);

    // Asynchronous reset mid-frame
    send_bits({1'b1, 8'h55, 1'b0}, 5);
    check("t7_busy_pre", mif0.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_busy", mif0.busy, 0);
    check("t7_cnt",  mif0.word_cnt, 0);
    check("t7_addr", mif0.addr, 32'h0);
    check("t7_data", mif0.data, 0);
    check("t7_wr",   mif0.wr, 0);
    uart_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Parametrised UART-to-memory program loader; receives 8N1 serial bytes, packs them little-endian into DATA_W-bit words and emits one write strobe per complete word to the instruction/data memory port.
- Sits between the board RX pin and the memory write port; active only while `enable` is high (load mode), otherwise held idle.
- Adds over the previous loader: configurable baud divider and word width, input synchroniser, start-bit glitch rejection, stop-bit framing check, partial-word timeout, base address/stride, word counter and error flags.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (min 4).
- DATA_W, 32, write word width; multiple of 8, range 8..64.
- ADDR_W, 32, address width.
- BASE_ADDR, 0, address of the first word written.
- ADDR_STEP, 1, address increment per word (1 = word addressed, 4 = byte addressed).
- TIMEOUT_CLKS, 16*CLKS_PER_BIT*10, idle cycles after which a partial word is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  load mode; low = synchronous soft clear.
- uart_in  in  1  raw serial RX line, idle high.
- wr  out  1  one-cycle write strobe.
- addr  out  ADDR_W  write address, valid with wr.
- data  out  DATA_W  write data, valid with wr.
- busy  out  1  high while a frame is in progress or a partial word is held.
- word_cnt  out  16  words written since enable rose (saturates at 0xFFFF).
- frame_err  out  1  sticky: stop bit sampled low.
- timeout_err  out  1  sticky: partial word discarded by timeout.

Behaviour:
- Reset (rst high, async): wr=0, addr=BASE_ADDR, data=0, busy=0, word_cnt=0, frame_err=0, timeout_err=0, synchroniser flops=1, RX FSM=IDLE, byte_idx=0, counters=0.
- enable low: same values as reset applied synchronously every cycle; aborts any frame or partial word mid-operation. uart_in is ignored while enable is low.
- Input: two-flop synchroniser; all decisions use the second-stage value rx_s.
- RX FSM (bit counter cnt, 0..CLKS_PER_BIT-1):
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: when cnt==CLKS_PER_BIT/2-1, sample rx_s. If 1 -> IDLE (glitch, no error). If 0 -> DATA, cnt=0, bit=0.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s in LSB-first, cnt=0. After bit 7 -> STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s. If 1, byte_valid pulses. If 0, frame_err<=1 and the byte is dropped (byte_idx unchanged). Either way -> IDLE.
- Packing (BYTES=DATA_W/8): on byte_valid, the byte goes to data lane [8*byte_idx+7 : 8*byte_idx]. If byte_idx<BYTES-1, byte_idx increments. Otherwise byte_idx=0 and wr is asserted on the next cycle.
- Write timing:
  - wr is high exactly one cycle, the cycle after the stop-bit sample.
  - addr and data hold the word's values during that cycle.
  - addr advances by ADDR_STEP (mod 2^ADDR_W) the cycle after wr.
  - word_cnt increments with wr.
- Timeout: an idle counter runs while FSM==IDLE and byte_idx!=0. Reaching TIMEOUT_CLKS sets byte_idx=0 and timeout_err<=1; partial lanes are discarded and addr is unchanged. The counter clears on any start detect.
- Lanes not yet written in the current word keep their previous value; data is only meaningful when wr=1.
- busy = (FSM!=IDLE) | (byte_idx!=0).
- A start bit may be detected on the cycle immediately after returning to IDLE, so back-to-back frames are supported.

Decomposition:
- Shared package holds:
  - RX state encoding: IDLE=0, START=1, DATA=2, STOP=3.
  - `localparam` for BYTES.
  - Helper constant for the half-bit sample point.
- One sub-module: uart_rx_byte, containing the synchroniser, RX FSM and baud counter. Outputs: byte[7:0], byte_valid, frame_err_pulse, rx_idle.
- The top level does packing, addressing, timeout and flags.

Test Plan:
- CLKS_PER_BIT=16, DATA_W=32. Send bytes 0x78,0x56,0x34,0x12 -> single wr with addr=0, data=0x12345678; word_cnt=1; busy=0 afterwards.
- Send 8 bytes 0x01..0x08 back-to-back with ADDR_STEP=4, BASE_ADDR=0x100 -> wr at addr 0x100 data 0x04030201, then addr 0x104 data 0x08070605; word_cnt=2.
- 5-cycle low glitch on uart_in (< half bit) -> no state change past START, no wr, no flags.
- Frame with stop bit driven 0 -> frame_err=1, byte not packed. Next 4 good bytes -> one correct wr.
- Send 2 bytes, then idle TIMEOUT_CLKS -> timeout_err=1, busy=0, no wr. Next 4 bytes -> wr at BASE_ADDR.
- Deassert enable mid-DATA of byte 3 -> all outputs return to reset values next cycle. Re-enable and send 4 bytes -> wr at BASE_ADDR, word_cnt=1. Also assert rst mid-frame -> immediate reset values.
